// File: rtl/sram_controller.sv
// Word-wide controller for a 16-bit asynchronous SRAM: each 32-bit load/store runs as two half-word phases.
// Optional macro SRAM_CTRL_CNT_EN adds a saturating completed-access counter port.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  inout  logic [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N
`ifdef SRAM_CTRL_CNT_EN
  ,
  output logic [15:0]       access_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-2:0]   word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic                dq_oe;
  logic [15:0]         dq_out;
  logic                last;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:ADDR_W+1], address[1:0]};

  assign last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    ready       = 1'b0;
    SRAM_WE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    dq_oe       = 1'b0;
    dq_out      = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
    case (state_q)
      IDLE: begin
        ready = ~(rd_en | wr_en);
        if (rd_en | wr_en) begin
          word_d      = address[ADDR_W:2];
          wdata_d     = write_data;
          is_wr_d     = wr_en;
          cnt_d       = '0;
          sram_addr_d = {address[ADDR_W:2], 1'b0};
          state_d     = LOW;
        end
      end
      LOW, HIGH: begin
        // The write strobe rises entering the last phase cycle; that edge commits the half-word.
        if (is_wr_q) begin
          dq_oe     = 1'b1;
          SRAM_WE_N = last;
        end else begin
          SRAM_OE_N = 1'b0;
        end
        if (last) begin
          cnt_d = '0;
          if (state_q == LOW) begin
            if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
            sram_addr_d = {word_q, 1'b1};
            state_d     = HIGH;
          end else begin
            if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign SRAM_ADDR = sram_addr_q;
  assign read_data = rdata_q;

`ifdef SRAM_CTRL_CNT_EN
  logic [15:0] access_count_q, access_count_d;

  always_comb begin
    access_count_d = access_count_q;
    if (state_q == DONE && access_count_q != '1) access_count_d = access_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) access_count_q <= '0;
    else        access_count_q <= access_count_d;
  end

  assign access_count = access_count_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: a word-level memory model predicts each access,
// a negedge monitor checks phase timing, strobes, addresses, latency and load data.
module tb_sram_controller;
  localparam int unsigned W  = 2;
  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   write_data = '0;
  logic [31:0]   read_data;
  logic          ready;
  wire  [15:0]   SRAM_DQ;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_WE_N;
  logic          SRAM_OE_N;
`ifdef SRAM_CTRL_CNT_EN
  logic [15:0]   access_count;
`endif

  sram_controller #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
`ifdef SRAM_CTRL_CNT_EN
    , .access_count(access_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Asynchronous SRAM: drives data while OE_N is low, writes on the rising edge of WE_N.
  logic [15:0] mem [0:(1<<AW)-1];
  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'bz;
  always @(posedge SRAM_WE_N) if (reset) mem[SRAM_ADDR] = SRAM_DQ;

  time we_fall;
  int  we_pulses = 0;
  bit  mon_en = 1'b0;
  always @(negedge SRAM_WE_N) we_fall = $time;
  always @(posedge SRAM_WE_N) if (reset && mon_en) begin
    we_pulses++;
    chk("we_pulse_width", 64'($time - we_fall), 64'((W - 1) * 10));
  end

  // Reference model: whole 32-bit words indexed by word address, plus the last load result.
  typedef struct { bit is_wr; logic [31:0] addr; logic [31:0] data; } exp_t;
  logic [31:0] model [int];
  logic [31:0] last_rd = '0;
  exp_t        q [$];
  int          completed = 0;

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   key;
    bit   done;
    key     = int'(a[AW:2]);
    e.is_wr = wr;
    e.addr  = a;
    if (wr) begin
      model[key] = d;
      e.data     = last_rd;
    end else begin
      e.data  = model.exists(key) ? model[key] : 32'h0;
      last_rd = e.data;
    end
    q.push_back(e);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    done = 1'b0;
    for (int i = 0; i < 4 * W + 10 && !done; i++) begin
      @(negedge clk);
      if (ready) done = 1'b1;
    end
    if (!done) chk("access_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  bit   active = 1'b0;
  int   k = 0;
  exp_t cur;
  always @(negedge clk) if (mon_en) begin
    if (rd_en | wr_en) begin
      if (!active) begin
        active = 1'b1;
        k = 0;
        if (q.size() == 0) chk("queue_empty", 64'd0, 64'd1);
        else cur = q[0];
      end else begin
        k++;
      end
      chk("oe_n", 64'(SRAM_OE_N), 64'(!(!cur.is_wr && k >= 1 && k <= 2 * W)));
      chk("we_n", 64'(SRAM_WE_N),
          64'(!(cur.is_wr && k >= 1 && k <= 2 * W && k != W && k != 2 * W)));
      chk("ready_busy", 64'(ready), 64'(k == 2 * W + 1));
      if (k >= 1 && k <= 2 * W)
        chk("sram_addr", 64'(SRAM_ADDR), 64'({cur.addr[AW:2], (k > W) ? 1'b1 : 1'b0}));
      if (ready) begin
        if (q.size() != 0) void'(q.pop_front());
        chk("latency", 64'(k), 64'(2 * W + 1));
        chk("read_data", 64'(read_data), 64'(cur.data));
        active = 1'b0;
        completed++;
      end
    end else begin
      chk("idle_ready", 64'(ready), 64'd1);
      chk("idle_we_n", 64'(SRAM_WE_N), 64'd1);
      chk("idle_oe_n", 64'(SRAM_OE_N), 64'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_we_n", 64'(SRAM_WE_N), 64'd1);
    chk("rst_oe_n", 64'(SRAM_OE_N), 64'd1);
    chk("rst_read_data", 64'(read_data), 64'd0);
    chk("rst_sram_addr", 64'(SRAM_ADDR), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    we_pulses = 0;
    do_access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("mem_hw8", 64'(mem[8]), 64'h BEEF);
    chk("mem_hw9", 64'(mem[9]), 64'h DEAD);
    chk("we_pulse_count", 64'(we_pulses), 64'd2);
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    chk("load_deadbeef", 64'(read_data), 64'hDEAD_BEEF);
    do_access(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    chk("load_12345678", 64'(read_data), 64'h1234_5678);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      a = $urandom;
      a[AW:2] = (AW - 1)'($urandom_range(0, 31));
      op = int'($urandom_range(0, 3));
      if (op == 0)      do_access(1'b0, 1'b1, a, $urandom);
      else if (op == 1) do_access(1'b1, 1'b1, a, $urandom);
      else              do_access(1'b1, 1'b0, a, $urandom);
    end

    // Abort a store in its second LOW cycle with an asynchronous reset.
    mon_en = 1'b0;
    wr_en = 1'b1; address = 32'h0000_4000; write_data = 32'hA5A5_5A5A;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("abort_we_n", 64'(SRAM_WE_N), 64'd1);
    chk("abort_oe_n", 64'(SRAM_OE_N), 64'd1);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_read_data", 64'(read_data), 64'd0);
    chk("abort_sram_addr", 64'(SRAM_ADDR), 64'd0);
    last_rd = '0;
    completed = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    do_access(1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_F00D);

`ifdef SRAM_CTRL_CNT_EN
    @(negedge clk);
    chk("access_count", 64'(access_count), 64'(completed));
    dut.access_count_q = 16'hFFFE;
    @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 32'h0000_0030, 32'h0);
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    chk("access_count_sat", 64'(access_count), 64'hFFFF);
`endif

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Word-wide external SRAM controller sitting directly downstream of the MEM stage: it accepts the MEM stage's 32-bit load/store requests (ALU result as address, Val_Rm as store data) and performs them as two 16-bit transfers on an asynchronous external SRAM. While an access is in flight it holds `ready` low; the top level uses `~ready` as a pipeline freeze for all stage registers. Load data is returned on `read_data` in the cycle `ready` rises, for capture by the MEM/WB register.

## Interface
- `WAIT_CYCLES`, default 2: cycles per 16-bit half-transfer; legal range 2..15.
- `ADDR_W`, default 18: external SRAM half-word address width.
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rd_en`  in  1  load request from the MEM stage; held until `ready` is seen high.
- `wr_en`  in  1  store request from the MEM stage; held until `ready` is seen high.
- `address`  in  32  byte address; bits [ADDR_W:2] select the word, bits [1:0] ignored.
- `write_data`  in  32  store data.
- `read_data`  out  32  load data; valid in the DONE cycle, held until the next load completes.
- `ready`  out  1  high = no access pending (pipeline may advance).
- `SRAM_DQ`  inout  16  SRAM data bus; driven only during write phases, otherwise high-Z.
- `SRAM_ADDR`  out  ADDR_W  half-word address, {address[ADDR_W:2], half}; half 0 = bits [15:0].
- `SRAM_WE_N`  out  1  active-low write strobe.
- `SRAM_OE_N`  out  1  active-low output enable.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. Phase counter 4 bits.
- IDLE: if `wr_en | rd_en`, latch `address`, `write_data`, and op type (`wr_en` wins when both are high, i.e. a write), clear the counter, go to LOW. Otherwise stay.
- LOW: `SRAM_ADDR` = {word, 0}. Count to WAIT_CYCLES-1, then go to HIGH. On a read, sample `SRAM_DQ` into `read_data[15:0]` in the last LOW cycle.
- HIGH: `SRAM_ADDR` = {word, 1}. Count as in LOW, then go to DONE. On a read, sample `SRAM_DQ` into `read_data[31:16]` in the last HIGH cycle.
- DONE: one cycle, then go unconditionally to IDLE.
- Write phases: `SRAM_DQ` carries the matching latched half for the whole phase. `SRAM_WE_N` is low in every phase cycle except the last; that cycle is the deassert edge that commits the data. `SRAM_OE_N` is high.
- Read phases: `SRAM_OE_N` is low, `SRAM_WE_N` is high, `SRAM_DQ` is high-Z.
- IDLE and DONE: `SRAM_WE_N` = `SRAM_OE_N` = 1; `SRAM_DQ` is high-Z; `SRAM_ADDR` holds its last value.
- `ready` is combinational: in IDLE it is `~(rd_en|wr_en)`; in LOW and HIGH it is 0; in DONE it is 1.
- Request inputs are ignored outside IDLE, because the latched copies are used instead.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, counter 0, `read_data`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ` high-Z. `ready` then follows the IDLE rule.
- Latency: a request first seen in IDLE at cycle 0 holds `ready` low for cycles 0..2·WAIT_CYCLES, and `ready` is high in cycle 2·WAIT_CYCLES+1 (DONE). With WAIT_CYCLES=2, `ready` is low in cycles 0–4 and high in cycle 5.
- The pipeline advances at the DONE clock edge. A new request present in the following IDLE cycle starts immediately, so back-to-back accesses have exactly one IDLE cycle between DONE and LOW.
- Reset during LOW or HIGH aborts the access. A write may leave the SRAM partially written; no recovery is attempted.
- `read_data` is not modified by writes.

## Configuration
- `SRAM_CTRL_CNT_EN` defined: adds output port `access_count` (out, 16 bits). It resets to 0, increments by 1 in every DONE cycle, and saturates at 16'hFFFF.
- `SRAM_CTRL_CNT_EN` not defined: the port and the counter logic are absent; all other behaviour is identical.

## Test plan
- Reset release with no request: `ready`=1, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z, `read_data`=0.
- Store `write_data`=32'hDEADBEEF to `address`=32'h0000_0010 (WAIT_CYCLES=2):
  - SRAM model shows half-word 8 = 16'hBEEF and half-word 9 = 16'hDEAD.
  - Two `SRAM_WE_N` low pulses, each one cycle long.
  - `ready` low in cycles 0–4, high in cycle 5.
- Load from `address`=32'h10 after that store: `read_data`=32'hDEADBEEF in the DONE cycle, with `SRAM_OE_N` low only during LOW and HIGH.
- `rd_en`=`wr_en`=1 together with data 32'h12345678 to `address` 32'h20: performed as a write; a subsequent load from 32'h20 returns 32'h12345678.
- Reset pulsed in the second LOW cycle of a store: all outputs return to their reset values immediately, and the next request completes with normal latency.
- With `SRAM_CTRL_CNT_EN` defined: 3 accesses give `access_count`=3. Starting from a forced count of 16'hFFFE, further accesses saturate at 16'hFFFF.
